rv32_writeback_unit: RTL and testbench
======================================

Name: rv32_writeback_unit

Overview:
- Writer side of the RV32 register-file write port. It drives write_reg, sel_d1 and reg_d1 from the final pipeline stage.
- Accepts one retiring instruction at a time from the MEM/WB boundary and selects the result: ALU result, PC+4, or a formatted load.
- For loads, waits a variable number of cycles for data-memory read data, then aligns and sign- or zero-extends it.
- Also holds the 64-bit instructions-retired counter.

Parameters:
- LOAD_TIMEOUT, 16, maximum number of WAIT_LOAD cycles before the load is abandoned with an error.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  retiring instruction is presented
- wb_ready  out  1  unit accepts the presented instruction this cycle
- wb_src  in  2  result source, type wb_src_e
- wb_rd  in  5  destination register
- wb_alu_result  in  32  ALU result
- wb_pc_plus4  in  32  link value
- wb_funct3  in  3  load type
- wb_addr_lo  in  2  load byte offset (address bits [1:0])
- dmem_rvalid  in  1  load read data is valid
- dmem_rdata  in  32  raw aligned word from data memory
- write_reg  out  1  register-file write enable
- sel_d1  out  5  register-file write address
- reg_d1  out  32  register-file write data
- load_err  out  1  one-cycle pulse: misaligned load, illegal funct3, or timeout
- instret  out  64  count of retired instructions

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high. While rst is high:
  - state is IDLE;
  - write_reg, sel_d1, reg_d1, load_err and instret are all 0;
  - the timeout counter is 0.
- Outputs: write_reg, sel_d1, reg_d1, load_err and instret are registered. wb_ready is combinational and equals (state==IDLE).
- States: IDLE and WAIT_LOAD.
- IDLE, accepting an instruction (wb_valid & wb_ready):
  - wb_src = WB_ALU or WB_PC4: on the next cycle write_reg=(wb_rd!=0), sel_d1=wb_rd, reg_d1 = selected value, instret+1. State stays IDLE. One instruction per cycle can be sustained.
  - wb_src = WB_NONE (stores, branches): write_reg=0 next cycle, instret+1.
  - wb_src = WB_LOAD: capture rd, funct3 and addr_lo, clear the timeout counter, go to WAIT_LOAD. Nothing is written yet.
- WAIT_LOAD:
  - wb_ready=0. Upstream holds its instruction.
  - The timeout counter increments every cycle.
  - On dmem_rvalid, format the data as below and return to IDLE.
    - Legal load: next cycle write_reg=(rd!=0), sel_d1=rd, reg_d1=formatted data, instret+1.
    - Illegal load: next cycle write_reg=0, load_err=1, instret unchanged.
  - If the counter reaches LOAD_TIMEOUT-1 with no dmem_rvalid: next cycle load_err=1, write_reg=0, return to IDLE.
  - Latency from dmem_rvalid to write_reg is exactly 1 cycle.
- Load formatting. Byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16].
  - LB (000): sign-extended byte.
  - LBU (100): zero-extended byte.
  - LH (001): sign-extended half. Illegal if addr_lo[0]=1.
  - LHU (101): zero-extended half. Illegal if addr_lo[0]=1.
  - LW (010): whole word. Illegal if addr_lo!=0.
  - Any other funct3 is illegal.
- Default pulses: write_reg and load_err are 0 in any cycle not listed above. sel_d1 and reg_d1 hold their last value when write_reg=0.
- rd=0: never produces write_reg=1, even for loads.
- Stray data: dmem_rvalid in IDLE is ignored. A response that arrives after a timeout is therefore discarded.
- Counter width: instret wraps modulo 2^64.
- Reset mid-load: rst during WAIT_LOAD returns the unit to IDLE immediately. The pending load is dropped and no write occurs.

Decomposition:
- Package rv32_wb_pkg:
  - wb_src_e: WB_ALU=0, WB_LOAD=1, WB_PC4=2, WB_NONE=3.
  - wb_state_e: IDLE, WAIT_LOAD.
  - Load funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module rv32_load_align: purely combinational. Inputs funct3, addr_lo, rdata; outputs data[31:0] and illegal.

Test Plan:
1. ALU retire: wb_src=WB_ALU, rd=5, alu=0xDEADBEEF.
   - Next cycle: write_reg=1, sel_d1=5, reg_d1=0xDEADBEEF, instret=1.
   - Repeat back-to-back with rd=6 and rd=7: three consecutive write cycles, instret=3.
2. rd=0: WB_PC4 with rd=0, pc_plus4=0x104.
   - write_reg stays 0; instret still increments.
3. Signed and unsigned byte loads: LB, addr_lo=2, rd=9, rdata=0x12803456, dmem_rvalid after 3 wait cycles.
   - wb_ready=0 for all 3 wait cycles.
   - Cycle after rvalid: write_reg=1, sel_d1=9, reg_d1=0xFFFFFF80.
   - Same case with LBU gives reg_d1=0x00000080.
4. Misaligned word load: LW, addr_lo=2, rvalid with any data.
   - load_err pulses for 1 cycle, write_reg=0, instret unchanged, state IDLE.
5. Timeout: LOAD_TIMEOUT=16, LH with no rvalid.
   - load_err pulses after 16 wait cycles and wb_ready returns to 1.
   - A late dmem_rvalid (0xFFFF) produces no write.
6. Reset mid-load: assert rst 2 cycles into WAIT_LOAD.
   - All outputs are 0 asynchronously; wb_ready=1 after release.
   - Subsequent dmem_rvalid is ignored.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: shared types and load encodings for the RV32 writeback unit
package rv32_wb_pkg;
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: extracts, aligns and extends load data from a raw memory word
module rv32_load_align
  import rv32_wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*addr_lo +: 8];
  assign h = rdata[16*addr_lo[1] +: 16];
  // select the extension for the load type and flag bad alignment or encodings
  always_comb begin
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LBU ? {24'd0, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'd0, h} :
           rdata;
    illegal = (funct3 == F3_LB || funct3 == F3_LBU) ? 1'b0 :
              (funct3 == F3_LH || funct3 == F3_LHU) ? addr_lo[0] :
              funct3 == F3_LW ? (addr_lo != 2'd0) :
              1'b1;
  end
endmodule

// File: rtl/rv32_writeback_unit.sv
// rv32_writeback_unit: selects the retiring result, waits for loads and drives the register-file write port
module rv32_writeback_unit
  import rv32_wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [1:0]      wb_src,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_pc_plus4,
  input  logic [2:0]      wb_funct3,
  input  logic [1:0]      wb_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            write_reg,
  output logic [4:0]      sel_d1,
  output logic [XLEN-1:0] reg_d1,
  output logic            load_err,
  output logic [63:0]     instret
);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  wb_state_e state;
  wb_src_e src;
  logic [CW-1:0] cnt;
  logic [4:0] ld_rd;
  logic [2:0] ld_f3;
  logic [1:0] ld_alo;
  logic [XLEN-1:0] ld_data;
  logic ld_ill;
  assign src = wb_src_e'(wb_src);
  assign wb_ready = state == IDLE;
  rv32_load_align u_align (
    .funct3 (ld_f3),
    .addr_lo(ld_alo),
    .rdata  (dmem_rdata),
    .data   (ld_data),
    .illegal(ld_ill)
  );
  // retire one instruction per cycle; loads park in WAIT_LOAD until data or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_rd     <= '0;
      ld_f3     <= '0;
      ld_alo    <= '0;
      write_reg <= 1'b0;
      sel_d1    <= '0;
      reg_d1    <= '0;
      load_err  <= 1'b0;
      instret   <= '0;
    end else begin
      write_reg <= 1'b0;
      load_err  <= 1'b0;
      if (state == IDLE) begin
        if (wb_valid) begin
          if (src == WB_LOAD) begin
            ld_rd  <= wb_rd;
            ld_f3  <= wb_funct3;
            ld_alo <= wb_addr_lo;
            cnt    <= '0;
            state  <= WAIT_LOAD;
          end else begin
            instret <= instret + 64'd1;
            if (src != WB_NONE && wb_rd != 5'd0) begin
              write_reg <= 1'b1;
              sel_d1    <= wb_rd;
              reg_d1    <= src == WB_PC4 ? wb_pc_plus4 : wb_alu_result;
            end
          end
        end
      end else if (dmem_rvalid) begin
        state <= IDLE;
        if (ld_ill) begin
          load_err <= 1'b1;
        end else begin
          instret <= instret + 64'd1;
          if (ld_rd != 5'd0) begin
            write_reg <= 1'b1;
            sel_d1    <= ld_rd;
            reg_d1    <= ld_data;
          end
        end
      end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
        load_err <= 1'b1;
        state    <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rv32_writeback_unit.sv
// tb_rv32_writeback_unit: scoreboard bench with directed writeback and load vectors
module tb_rv32_writeback_unit;
  import rv32_wb_pkg::*;
  typedef struct {
    logic        err;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [63:0] ir;
  } exp_t;
  logic clk = 0, rst = 1;
  logic wb_valid = 0, dmem_rvalid = 0;
  logic wb_ready, write_reg, load_err;
  logic [1:0] wb_src = 0, wb_addr_lo = 0;
  logic [4:0] wb_rd = 0, sel_d1;
  logic [2:0] wb_funct3 = 0;
  logic [31:0] wb_alu_result = 0, wb_pc_plus4 = 0, dmem_rdata = 0, reg_d1;
  logic [63:0] instret;
  logic [63:0] exp_ir = 0;
  exp_t q[$];
  int total = 0, bad = 0;
  rv32_writeback_unit #(.LOAD_TIMEOUT(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_src(wb_src),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_pc_plus4(wb_pc_plus4),
    .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .write_reg(write_reg), .sel_d1(sel_d1), .reg_d1(reg_d1),
    .load_err(load_err), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic push(input logic err, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.err = err; e.rd = rd; e.data = data; e.ir = exp_ir;
    q.push_back(e);
  endtask
  // present one instruction for a single cycle; wb_ready must be high to accept it
  task automatic issue(input wb_src_e s, input logic [4:0] rd, input logic [31:0] v,
                       input logic [2:0] f3, input logic [1:0] alo);
    wb_src = s; wb_rd = rd; wb_alu_result = v; wb_pc_plus4 = v; wb_funct3 = f3; wb_addr_lo = alo;
    wb_valid = 1;
    chk("ready_on_issue", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 0;
  endtask
  task automatic rvalid(input logic [31:0] d);
    dmem_rvalid = 1; dmem_rdata = d;
    @(posedge clk); #1;
    dmem_rvalid = 0;
  endtask
  // monitor: every write or error pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (write_reg || load_err)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: write_reg=%0b load_err=%0b sel=%0d data=%0h", write_reg, load_err, sel_d1, reg_d1);
      end else begin
        exp_t e;
        logic ok;
        e = q.pop_front();
        ok = e.err ? (load_err && !write_reg && instret == e.ir)
                   : (write_reg && !load_err && sel_d1 == e.rd && reg_d1 == e.data && instret == e.ir);
        if (!ok) begin
          bad++;
          $display("FAIL scoreboard: got we=%0b err=%0b rd=%0d data=%0h ir=%0d want err=%0b rd=%0d data=%0h ir=%0d",
                   write_reg, load_err, sel_d1, reg_d1, instret, e.err, e.rd, e.data, e.ir);
        end
      end
    end
  end
  initial begin
    int n;
    #2;
    chk("reset_write_reg", write_reg, 0);
    chk("reset_sel_reg", {sel_d1, reg_d1}, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_instret", instret, 0);
    chk("reset_ready", wb_ready, 1);
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    exp_ir = 1; push(0, 5, 32'hDEADBEEF);
    issue(WB_ALU, 5, 32'hDEADBEEF, 0, 0);
    exp_ir = 2; push(0, 6, 32'h00000006);
    issue(WB_ALU, 6, 32'h00000006, 0, 0);
    exp_ir = 3; push(0, 7, 32'hA5A5A5A5);
    issue(WB_ALU, 7, 32'hA5A5A5A5, 0, 0);
    chk("alu_instret3", instret, 3);
    exp_ir = 4;
    issue(WB_PC4, 0, 32'h104, 0, 0);
    chk("rd0_no_write", write_reg, 0);
    chk("rd0_instret", instret, 4);
    exp_ir = 5; push(0, 12, 32'h00000104);
    issue(WB_PC4, 12, 32'h104, 0, 0);
    exp_ir = 5;
    issue(WB_NONE, 3, 32'h55, 0, 0);
    chk("none_no_write", write_reg, 0);
    chk("none_instret", instret, 6);
    exp_ir = 6;
    issue(WB_LOAD, 9, 0, F3_LB, 2);
    for (int i = 0; i < 3; i++) begin
      chk("lb_wait_ready", wb_ready, 0);
      @(posedge clk); #1;
    end
    exp_ir = 7; push(0, 9, 32'hFFFFFF80);
    rvalid(32'h12803456);
    chk("lb_ready_after", wb_ready, 1);
    issue(WB_LOAD, 9, 0, F3_LBU, 2);
    @(posedge clk); #1;
    exp_ir = 8; push(0, 9, 32'h00000080);
    rvalid(32'h12803456);
    issue(WB_LOAD, 10, 0, F3_LH, 2);
    exp_ir = 9; push(0, 10, 32'hFFFF8001);
    rvalid(32'h80011234);
    issue(WB_LOAD, 11, 0, F3_LHU, 0);
    exp_ir = 10; push(0, 11, 32'h00009ABC);
    rvalid(32'h12349ABC);
    issue(WB_LOAD, 13, 0, F3_LW, 0);
    exp_ir = 11; push(0, 13, 32'hCAFEF00D);
    rvalid(32'hCAFEF00D);
    issue(WB_LOAD, 0, 0, F3_LW, 0);
    exp_ir = 12;
    rvalid(32'h11111111);
    chk("load_rd0_no_write", write_reg, 0);
    chk("load_rd0_instret", instret, 12);
    issue(WB_LOAD, 4, 0, F3_LW, 2);
    @(posedge clk); #1;
    push(1, 0, 0);
    rvalid(32'h77777777);
    chk("misalign_no_write", write_reg, 0);
    chk("misalign_instret", instret, 12);
    chk("misalign_ready", wb_ready, 1);
    issue(WB_LOAD, 4, 0, F3_LHU, 1);
    push(1, 0, 0);
    rvalid(32'h77777777);
    issue(WB_LOAD, 4, 0, 3'b011, 0);
    push(1, 0, 0);
    rvalid(32'h77777777);
    chk("illegal_instret", instret, 12);
    issue(WB_LOAD, 8, 0, F3_LH, 0);
    push(1, 0, 0);
    n = 0;
    while (!wb_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_wait_cycles", n, 16);
    chk("timeout_instret", instret, 12);
    rvalid(32'h0000FFFF);
    chk("late_rvalid_no_write", write_reg, 0);
    issue(WB_LOAD, 3, 0, F3_LW, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midreset_write_reg", write_reg, 0);
    chk("midreset_sel_reg", {sel_d1, reg_d1}, 0);
    chk("midreset_load_err", load_err, 0);
    chk("midreset_instret", instret, 0);
    chk("midreset_ready", wb_ready, 1);
    #1 rst = 0;
    exp_ir = 0;
    @(posedge clk); #1;
    rvalid(32'h12345678);
    chk("postreset_ready", wb_ready, 1);
    chk("postreset_no_write", write_reg, 0);
    exp_ir = 1; push(0, 1, 32'h0BADF00D);
    issue(WB_ALU, 1, 32'h0BADF00D, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
